// File: rtl/sp_if_ddr_pkg.sv
// Shared types and widths for the DDR access-port arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package sp_if_ddr_pkg;

  localparam int DDR_AREA_W = 4;
  localparam int DDR_ADDR_W = 27;
  localparam int DDR_SIZE_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                  wxr;
    logic [DDR_AREA_W-1:0] area;
    logic [DDR_ADDR_W-1:0] addr;
    logic [DDR_SIZE_W-1:0] size;
  } ddr_req_t;

endpackage

// File: rtl/sp_if_ddr_rr_sel.sv
// Rotating priority encoder: first set request bit after ptr, wrapping NREQ-1 -> 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to consume the selection.
module sp_if_ddr_rr_sel
  import sp_if_ddr_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GRW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GRW-1:0]  ptr,
  output logic            vld,
  output logic [GRW-1:0]  idx
);

  int j;

  // Scan from the farthest candidate back to ptr+1 so the nearest hit is written last and wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        vld = 1'b1;
        idx = GRW'(j);
      end
    end
  end

endmodule

// File: rtl/sp_if_ddr_arb.sv
// Round-robin arbiter sharing one DDR access port among NREQ level-held sequencer requests.
// Latency: request level to o_ddr_start is 2 cycles; i_ddr_endp to o_req_endp is 1 cycle.
// Backpressure: ungranted requests simply stay pending; a grant is held until its start level drops.
module sp_if_ddr_arb
  import sp_if_ddr_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GRW  = $clog2(NREQ)
) (
  input  logic                       i_clk156m,
  input  logic                       i_arst,
  input  logic [NREQ-1:0]            i_req_start,
  input  logic [NREQ-1:0]            i_req_wxr,
  input  logic [NREQ*DDR_AREA_W-1:0] i_req_area,
  input  logic [NREQ*DDR_ADDR_W-1:0] i_req_addr,
  input  logic [NREQ*DDR_SIZE_W-1:0] i_req_size,
  input  logic [15:0]                i_tmo_max,
  input  logic                       i_ddr_endp,
  output logic                       o_ddr_wxr,
  output logic [DDR_AREA_W-1:0]      o_ddr_area,
  output logic [DDR_ADDR_W-1:0]      o_ddr_addr,
  output logic [DDR_SIZE_W-1:0]      o_ddr_size,
  output logic                       o_ddr_start,
  output logic [NREQ-1:0]            o_req_endp,
  output logic [NREQ-1:0]            o_grant,
  output logic                       o_busy,
  output logic                       o_tmo_err
);

  arb_state_t     state;
  logic [GRW-1:0] gnt_idx;
  logic [GRW-1:0] rr_ptr;
  logic [GRW-1:0] sel_idx;
  logic           sel_vld;
  logic [15:0]    tmo_cnt;
  logic           tmo_hit;
  ddr_req_t       sel_req;
  ddr_req_t       ddr_q;

  sp_if_ddr_rr_sel #(
    .NREQ (NREQ),
    .GRW  (GRW)
  ) u_rr_sel (
    .req  (i_req_start),
    .ptr  (rr_ptr),
    .vld  (sel_vld),
    .idx  (sel_idx)
  );

  // Pick out the granted requester's fields from the flattened input buses.
  always_comb begin
    sel_req      = '0;
    sel_req.wxr  = i_req_wxr[gnt_idx];
    sel_req.area = i_req_area[int'(gnt_idx)*DDR_AREA_W +: DDR_AREA_W];
    sel_req.addr = i_req_addr[int'(gnt_idx)*DDR_ADDR_W +: DDR_ADDR_W];
    sel_req.size = i_req_size[int'(gnt_idx)*DDR_SIZE_W +: DDR_SIZE_W];
  end

  // A zero limit disables the watchdog; otherwise it expires on the limit-th BUSY cycle.
  assign tmo_hit = (i_tmo_max != 16'd0) && (tmo_cnt == (i_tmo_max - 16'd1));

  assign o_busy     = (state != IDLE);
  assign o_ddr_wxr  = ddr_q.wxr;
  assign o_ddr_area = ddr_q.area;
  assign o_ddr_addr = ddr_q.addr;
  assign o_ddr_size = ddr_q.size;

  // Arbiter FSM: grant, issue, wait for completion or timeout, then wait for the start level to drop.
  always_ff @(posedge i_clk156m or posedge i_arst) begin
    if (i_arst) begin
      state       <= IDLE;
      gnt_idx     <= '0;
      rr_ptr      <= GRW'(NREQ-1);
      tmo_cnt     <= '0;
      ddr_q       <= '0;
      o_ddr_start <= 1'b0;
      o_req_endp  <= '0;
      o_grant     <= '0;
      o_tmo_err   <= 1'b0;
    end else begin
      o_req_endp <= '0;
      o_tmo_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            gnt_idx <= sel_idx;
            o_grant <= NREQ'(1) << sel_idx;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          ddr_q       <= sel_req;
          o_ddr_start <= 1'b1;
          tmo_cnt     <= '0;
          state       <= BUSY;
        end
        BUSY: begin
          if (i_ddr_endp || tmo_hit) begin
            // A completion arriving on the expiry cycle wins: no error is flagged.
            o_ddr_start <= 1'b0;
            o_req_endp  <= NREQ'(1) << gnt_idx;
            o_tmo_err   <= ~i_ddr_endp;
            rr_ptr      <= gnt_idx;
            state       <= RELEASE;
          end else if (tmo_cnt != 16'hFFFF) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RELEASE: begin
          // Hold the grant until the owner drops start so a stale level is not re-granted.
          if (!i_req_start[gnt_idx]) begin
            o_grant <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_if_ddr_arb.sv
module tb_sp_if_ddr_arb;

  localparam int NREQ = 4;
  localparam int GRW  = 2;

  logic              i_clk156m = 1'b0;
  logic              i_arst;
  logic [NREQ-1:0]   i_req_start;
  logic [NREQ-1:0]   i_req_wxr;
  logic [NREQ*4-1:0] i_req_area;
  logic [NREQ*27-1:0] i_req_addr;
  logic [NREQ*32-1:0] i_req_size;
  logic [15:0]       i_tmo_max;
  logic              i_ddr_endp;
  logic              o_ddr_wxr;
  logic [3:0]        o_ddr_area;
  logic [26:0]       o_ddr_addr;
  logic [31:0]       o_ddr_size;
  logic              o_ddr_start;
  logic [NREQ-1:0]   o_req_endp;
  logic [NREQ-1:0]   o_grant;
  logic              o_busy;
  logic              o_tmo_err;

  int tests = 0;
  int fails = 0;

  logic [NREQ+63:0] gnt_q[$];
  logic [NREQ:0]    end_q[$];
  logic [NREQ+63:0] mon_g;
  logic [NREQ:0]    mon_e;
  logic             prev_start = 1'b0;

  sp_if_ddr_arb #(.NREQ(NREQ), .GRW(GRW)) dut (
    .i_clk156m   (i_clk156m),
    .i_arst      (i_arst),
    .i_req_start (i_req_start),
    .i_req_wxr   (i_req_wxr),
    .i_req_area  (i_req_area),
    .i_req_addr  (i_req_addr),
    .i_req_size  (i_req_size),
    .i_tmo_max   (i_tmo_max),
    .i_ddr_endp  (i_ddr_endp),
    .o_ddr_wxr   (o_ddr_wxr),
    .o_ddr_area  (o_ddr_area),
    .o_ddr_addr  (o_ddr_addr),
    .o_ddr_size  (o_ddr_size),
    .o_ddr_start (o_ddr_start),
    .o_req_endp  (o_req_endp),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_tmo_err   (o_tmo_err)
  );

  always #4 i_clk156m = ~i_clk156m;

  task automatic tick();
    @(posedge i_clk156m);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [3:0] a,
                         input logic [26:0] ad, input logic [31:0] s);
    i_req_wxr[i]           = w;
    i_req_area[i*4 +: 4]   = a;
    i_req_addr[i*27 +: 27] = ad;
    i_req_size[i*32 +: 32] = s;
  endtask

  // Expected grant record: one-hot grant followed by the requester's programmed fields.
  task automatic exp_gnt(input int i);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    gnt_q.push_back({oh, i_req_wxr[i], i_req_area[i*4 +: 4],
                     i_req_addr[i*27 +: 27], i_req_size[i*32 +: 32]});
  endtask

  task automatic exp_end(input int i, input logic t);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    end_q.push_back({oh, t});
  endtask

  task automatic wait_start(output bit ok);
    int n;
    n = 0;
    while (!o_ddr_start && n < 50) begin
      tick();
      n++;
    end
    ok = o_ddr_start;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_start: o_ddr_start still %0b after %0d cycles, required 1", o_ddr_start, n);
    end
  endtask

  // Play the sequencer side for n accesses: complete after dly cycles, drop start,
  // and optionally re-raise start for requesters in reas.
  task automatic serve(input int n, input int dly, input logic [NREQ-1:0] reas);
    bit ok;
    int g;
    for (int k = 0; k < n; k++) begin
      wait_start(ok);
      if (!ok) return;
      g = -1;
      for (int b = 0; b < NREQ; b++) if (o_grant[b]) g = b;
      if (g < 0) begin
        tests++;
        fails++;
        $display("FAIL serve_grant: o_grant %b while o_ddr_start high, required one-hot", o_grant);
        return;
      end
      repeat (dly) tick();
      i_ddr_endp = 1'b1;
      tick();
      i_ddr_endp = 1'b0;
      i_req_start[g] = 1'b0;
      tick();
      if (reas[g]) begin
        tick();
        i_req_start[g] = 1'b1;
      end
    end
  endtask

  // Scoreboard monitor: every new access and every completion is popped against the queues.
  always @(negedge i_clk156m) begin
    if (!i_arst) begin
      if (o_ddr_start && !prev_start) begin
        tests++;
        if (gnt_q.size() == 0) begin
          fails++;
          $display("FAIL sb_grant: unexpected access with grant %b, none required", o_grant);
        end else begin
          mon_g = gnt_q.pop_front();
          if ({o_grant, o_ddr_wxr, o_ddr_area, o_ddr_addr, o_ddr_size} !== mon_g) begin
            fails++;
            $display("FAIL sb_grant: got %0h required %0h",
                     {o_grant, o_ddr_wxr, o_ddr_area, o_ddr_addr, o_ddr_size}, mon_g);
          end
        end
      end
      if (o_req_endp != '0 || o_tmo_err) begin
        tests++;
        if (end_q.size() == 0) begin
          fails++;
          $display("FAIL sb_endp: unexpected endp %b tmo %0b, none required", o_req_endp, o_tmo_err);
        end else begin
          mon_e = end_q.pop_front();
          if ({o_req_endp, o_tmo_err} !== mon_e) begin
            fails++;
            $display("FAIL sb_endp: got endp/tmo %0h required %0h", {o_req_endp, o_tmo_err}, mon_e);
          end
        end
      end
      if (!$onehot0(o_grant)) begin
        tests++;
        fails++;
        $display("FAIL grant_onehot: got %b required at most one bit", o_grant);
      end
    end
    prev_start = o_ddr_start;
  end

  initial begin
    bit ok;
    bit stay;
    int cnt;

    i_arst = 1'b1;
    i_req_start = '0;
    i_req_wxr = '0;
    i_req_area = '0;
    i_req_addr = '0;
    i_req_size = '0;
    i_tmo_max = 16'd0;
    i_ddr_endp = 1'b0;
    set_req(0, 1'b1, 4'h2, 27'h0001000, 32'h00000400);
    set_req(1, 1'b0, 4'h5, 27'h1234560, 32'h00000800);
    set_req(2, 1'b1, 4'hA, 27'h7FFFFF0, 32'h00000010);
    set_req(3, 1'b0, 4'hF, 27'h0ABCDE0, 32'hFFFFFFF0);
    repeat (3) @(posedge i_clk156m);
    #1;
    chk("reset_outputs", {o_ddr_start, o_busy, o_grant, o_req_endp, o_tmo_err,
                          o_ddr_wxr, o_ddr_area, o_ddr_addr, o_ddr_size}, '0);
    i_arst = 1'b0;
    tick();

    // Completion while idle is ignored.
    i_ddr_endp = 1'b1;
    tick();
    i_ddr_endp = 1'b0;
    chk("idle_endp_ignored", o_req_endp, 4'b0000);
    tick();

    // Single request with latency and release checks.
    exp_gnt(0);
    exp_end(0, 1'b0);
    i_req_start[0] = 1'b1;
    tick();
    chk("s1_issue_start_low", o_ddr_start, 1'b0);
    chk("s1_issue_grant", o_grant, 4'b0001);
    tick();
    chk("s1_start_high", o_ddr_start, 1'b1);
    chk("s1_busy", o_busy, 1'b1);
    repeat (3) tick();
    i_ddr_endp = 1'b1;
    tick();
    i_ddr_endp = 1'b0;
    chk("s1_req_endp", o_req_endp, 4'b0001);
    chk("s1_start_fall", o_ddr_start, 1'b0);
    tick();
    chk("s1_endp_one_cycle", o_req_endp, 4'b0000);
    chk("s1_grant_held", o_grant, 4'b0001);
    i_req_start[0] = 1'b0;
    tick();
    chk("s1_grant_clear", o_grant, 4'b0000);
    chk("s1_idle", o_busy, 1'b0);

    // All four at once from reset priority, then requester 0 again.
    i_arst = 1'b1;
    tick();
    i_arst = 1'b0;
    tick();
    for (int i = 0; i < NREQ; i++) begin
      exp_gnt(i);
      exp_end(i, 1'b0);
    end
    i_req_start = 4'b1111;
    serve(4, 2, 4'b0000);
    exp_gnt(0);
    exp_end(0, 1'b0);
    i_req_start[0] = 1'b1;
    serve(1, 2, 4'b0000);

    // Fairness: requester 1 keeps re-requesting, requester 2 must get in next.
    exp_gnt(1); exp_end(1, 1'b0);
    exp_gnt(2); exp_end(2, 1'b0);
    exp_gnt(1); exp_end(1, 1'b0);
    i_req_start[1] = 1'b1;
    i_req_start[2] = 1'b1;
    serve(2, 3, 4'b0010);
    serve(1, 3, 4'b0000);

    // Watchdog at 100 cycles on requester 3.
    i_tmo_max = 16'd100;
    exp_gnt(3);
    exp_end(3, 1'b1);
    i_req_start[3] = 1'b1;
    wait_start(ok);
    cnt = 0;
    while (o_ddr_start && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("wd_busy_cycles", cnt, 100);
    chk("wd_tmo_err", o_tmo_err, 1'b1);
    chk("wd_req_endp", o_req_endp, 4'b1000);
    tick();
    chk("wd_tmo_one_cycle", o_tmo_err, 1'b0);
    i_req_start[3] = 1'b0;
    tick();
    tick();

    // Watchdog disabled: no timeout over a long wait.
    i_tmo_max = 16'd0;
    exp_gnt(0);
    exp_end(0, 1'b0);
    i_req_start[0] = 1'b1;
    wait_start(ok);
    stay = 1'b1;
    repeat (70000) begin
      tick();
      if (!o_ddr_start || o_tmo_err) stay = 1'b0;
    end
    chk("wd_disabled_holds", stay, 1'b1);
    i_ddr_endp = 1'b1;
    tick();
    i_ddr_endp = 1'b0;
    chk("wd_disabled_endp", o_req_endp, 4'b0001);
    i_req_start[0] = 1'b0;
    tick();
    tick();

    // Completion on the expiry cycle wins over the timeout.
    i_tmo_max = 16'd5;
    exp_gnt(1);
    exp_end(1, 1'b0);
    i_req_start[1] = 1'b1;
    wait_start(ok);
    repeat (4) tick();
    i_ddr_endp = 1'b1;
    tick();
    i_ddr_endp = 1'b0;
    chk("co_req_endp", o_req_endp, 4'b0010);
    chk("co_no_tmo", o_tmo_err, 1'b0);
    i_req_start[1] = 1'b0;
    tick();
    tick();

    // Reset during BUSY, then reset priority favours requester 0 over 3.
    i_tmo_max = 16'd0;
    exp_gnt(2);
    i_req_start[2] = 1'b1;
    wait_start(ok);
    tick();
    i_arst = 1'b1;
    #1;
    chk("rst_busy_outputs", {o_ddr_start, o_busy, o_grant, o_req_endp, o_tmo_err,
                             o_ddr_wxr, o_ddr_area, o_ddr_addr, o_ddr_size}, '0);
    i_req_start = 4'b1001;
    exp_gnt(0); exp_end(0, 1'b0);
    exp_gnt(3); exp_end(3, 1'b0);
    tick();
    i_arst = 1'b0;
    serve(2, 1, 4'b0000);
    i_arst = 1'b1;
    tick();
    i_arst = 1'b0;
    exp_gnt(3);
    exp_end(3, 1'b0);
    i_req_start[3] = 1'b1;
    serve(1, 1, 4'b0000);

    repeat (4) tick();
    chk("sb_grant_drained", gnt_q.size(), 0);
    chk("sb_endp_drained", end_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
